// File: rtl/pm_loader_ctrl.sv
// Boot/load controller for the MPU341: streams a program image into PM
// and holds the MPU in reset until the image is complete.
module pm_loader_ctrl #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter int RELEASE_DELAY = 4
) (
    input  logic              clk,
    input  logic              sync_reset,
    input  logic              load_start,
    input  logic              load_abort,
    input  logic [ADDR_W:0]   load_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_waddr,
    output logic [DATA_W-1:0] pm_wdata,
    output logic              mpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] checksum
);

    localparam int HC_W = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(RELEASE_DELAY - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD,
        RUN
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_nx;
    logic [HC_W-1:0]   hold_cnt;
    logic              len_ok;
    logic              can_start;
    logic              active;
    logic              start_go;
    logic              acc;
    logic              last_word;
    logic              hold_last;

    assign len_ok    = (load_len != '0) && (load_len <= LEN_MAX);
    assign can_start = (state == IDLE) || (state == RUN);
    assign active    = (state == LOAD) || (state == HOLD);
    assign start_go  = can_start && load_start && len_ok;
    // An abort in the same cycle drops the byte entirely.
    assign acc       = (state == LOAD) && in_valid && !load_abort;
    assign count_nx  = count + 1'b1;
    assign last_word = (count_nx == len);
    assign hold_last = (hold_cnt == HOLD_LAST);

    assign in_ready  = (state == LOAD);
    assign busy      = active;
    // The MPU only runs once a complete image has been released.
    assign mpu_reset = (state != RUN);

    // State register.
    always_ff @(posedge clk) begin
        if (sync_reset) state <= IDLE;
        else            state <= state_nx;
    end

    // Next-state logic; abort wins over completion.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, RUN: begin
                if (start_go) state_nx = LOAD;
            end
            LOAD: begin
                if (load_abort)           state_nx = IDLE;
                else if (acc && last_word) state_nx = HOLD;
            end
            HOLD: begin
                if (load_abort)     state_nx = IDLE;
                else if (hold_last) state_nx = RUN;
            end
        endcase
    end

    // Write port, counters, checksum and status pulses.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pm_we    <= 1'b0;
            pm_waddr <= '0;
            pm_wdata <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            checksum <= '0;
            len      <= '0;
            count    <= '0;
            hold_cnt <= '0;
        end else begin
            pm_we <= acc;
            done  <= (state == HOLD) && !load_abort && hold_last;
            error <= (can_start && load_start && !len_ok) ||
                     (active && load_abort);
            if (state == HOLD) hold_cnt <= hold_cnt + 1'b1;
            else               hold_cnt <= '0;
            if (start_go) begin
                len      <= load_len;
                count    <= '0;
                checksum <= '0;
            end else if (acc) begin
                pm_waddr <= count[ADDR_W-1:0];
                pm_wdata <= in_data;
                checksum <= checksum + in_data;
                count    <= count_nx;
            end
        end
    end

endmodule
